// File: rtl/piece_scheduler_pkg.sv
// ============================================================================
//  Module      : tetris_pkg
//  Description : Shared piece/state types and helpers for the piece scheduler.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

package tetris_pkg;

    typedef logic [2:0] piece_t;

    localparam int NUM_PIECES = 7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_READY = 2'd2
    } sched_state_t;

    // (a + k) mod 7, used to walk the probe sequence around the piece ring
    function automatic piece_t piece_add(input piece_t a, input int k);
        int sum;
        sum = int'(a) + k;
        return piece_t'(sum % NUM_PIECES);
    endfunction

endpackage

`default_nettype wire

// File: rtl/piece_scheduler_if.sv
// ============================================================================
//  Module      : piece_scheduler_if
//  Description : Game-FSM <-> piece scheduler handshake and preview bundle.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

interface piece_scheduler_if
    import tetris_pkg::*;
#(
    parameter int PREVIEW_DEPTH = 3
);
    logic                         start;
    logic                         spawn_req;
    logic                         spawn_ack;
    piece_t                       spawn_piece;
    logic [3*PREVIEW_DEPTH-1:0]   preview;
    logic                         preview_valid;
    logic                         busy;

    modport master (
        output start, spawn_req,
        input  spawn_ack, spawn_piece, preview, preview_valid, busy
    );

    modport slave (
        input  start, spawn_req,
        output spawn_ack, spawn_piece, preview, preview_valid, busy
    );
endinterface

`default_nettype wire

// File: rtl/piece_scheduler_bag_picker.sv
// ============================================================================
//  Module      : bag_picker
//  Description : 7-bag mask plus first-free probe from the seed (used only
//                when PIECE_BAG7_EN is defined).
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module bag_picker
    import tetris_pkg::*;
(
    input  wire logic   CLK,
    input  wire logic   reset,
    input  wire piece_t seed,
    input  wire logic   draw,
    input  wire logic   clear,
    output piece_t      piece
);

    logic [NUM_PIECES-1:0] r_mask;
    logic [NUM_PIECES-1:0] w_mask_set;
    logic                  w_found;

    always_comb begin
        piece_t v_cand;
        piece   = seed;
        w_found = 1'b0;
        for (int k = 0; k < NUM_PIECES; k++) begin
            v_cand = piece_add(seed, k);
            if (!w_found && !r_mask[v_cand]) begin
                piece   = v_cand;
                w_found = 1'b1;
            end
        end
    end

    assign w_mask_set = r_mask | (NUM_PIECES'(1) << piece);

    // A completed bag empties on the same edge its last piece is taken
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            r_mask <= '0;
        end else if (clear) begin
            r_mask <= '0;
        end else if (draw) begin
            r_mask <= (&w_mask_set) ? '0 : w_mask_set;
        end
    end

endmodule

`default_nettype wire

// File: rtl/piece_scheduler.sv
// ============================================================================
//  Module      : piece_scheduler
//  Description : Seed counter, next-piece queue and spawn req/ack server.
//                Define PIECE_BAG7_EN for 7-bag fair draws.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module piece_scheduler
    import tetris_pkg::*;
#(
    parameter int PREVIEW_DEPTH = 3,
    parameter int SEED_RESET    = 0
)(
    input  wire logic          CLK,
    input  wire logic          reset,
    piece_scheduler_if.slave   sif
);

    localparam int c_QDEPTH = PREVIEW_DEPTH + 1;
    localparam int c_CNT_W  = $clog2(c_QDEPTH + 1);

    sched_state_t        r_state;
    sched_state_t        w_state_nxt;
    piece_t              r_seed;
    piece_t              w_piece;
    piece_t              r_queue [c_QDEPTH];
    logic [c_CNT_W-1:0]  r_count;
    logic                r_spawn_ack;
    piece_t              r_spawn_piece;
    logic                w_busy;
    logic                w_draw;
    logic                w_spawn;

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            r_seed <= piece_t'(SEED_RESET);
        end else begin
            r_seed <= (r_seed == piece_t'(NUM_PIECES - 1)) ? '0 : r_seed + 3'd1;
        end
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  w_state_nxt = ST_IDLE;
            ST_FILL:  if (r_count == c_CNT_W'(c_QDEPTH - 1)) w_state_nxt = ST_READY;
            ST_READY: if (sif.spawn_req) w_state_nxt = ST_FILL;
            default:  w_state_nxt = ST_IDLE;
        endcase
        if (sif.start) begin
            w_state_nxt = ST_FILL;
        end
    end

    // start has priority over both drawing and serving a spawn
    always_comb begin
        w_busy  = (r_state == ST_FILL);
        w_draw  = w_busy && !sif.start;
        w_spawn = (r_state == ST_READY) && sif.spawn_req && !sif.start;
    end

`ifdef PIECE_BAG7_EN
    bag_picker u_bag_picker (
        .CLK   (CLK),
        .reset (reset),
        .seed  (r_seed),
        .draw  (w_draw),
        .clear (sif.start),
        .piece (w_piece)
    );
`else
    assign w_piece = r_seed;
`endif

    // Vacated slots are zeroed so unfilled preview entries read as 0
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < c_QDEPTH; i++) r_queue[i] <= '0;
            r_count       <= '0;
            r_spawn_ack   <= 1'b0;
            r_spawn_piece <= '0;
        end else begin
            r_spawn_ack <= w_spawn;
            if (sif.start) begin
                for (int i = 0; i < c_QDEPTH; i++) r_queue[i] <= '0;
                r_count <= '0;
            end else if (w_draw) begin
                for (int i = 0; i < c_QDEPTH; i++) begin
                    if (r_count == c_CNT_W'(i)) r_queue[i] <= w_piece;
                end
                r_count <= r_count + c_CNT_W'(1);
            end else if (w_spawn) begin
                r_spawn_piece <= r_queue[0];
                for (int i = 0; i < c_QDEPTH - 1; i++) r_queue[i] <= r_queue[i+1];
                r_queue[c_QDEPTH-1] <= '0;
                r_count <= r_count - c_CNT_W'(1);
            end
        end
    end

    for (genvar gi = 0; gi < PREVIEW_DEPTH; gi++) begin : g_preview
        assign sif.preview[3*gi +: 3] = r_queue[gi+1];
    end

    assign sif.spawn_ack     = r_spawn_ack;
    assign sif.spawn_piece   = r_spawn_piece;
    assign sif.preview_valid = (r_count == c_CNT_W'(c_QDEPTH));
    assign sif.busy          = w_busy;

endmodule

`default_nettype wire
